// File: rtl/rv32_mem_pkg.sv
// Shared definitions for the RV32I MEM-stage load/store unit.
package rv32_mem_pkg;

    localparam logic [2:0] LS_B  = 3'b000;
    localparam logic [2:0] LS_H  = 3'b001;
    localparam logic [2:0] LS_W  = 3'b010;
    localparam logic [2:0] LS_BU = 3'b100;
    localparam logic [2:0] LS_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } lsu_state_t;

endpackage

// File: rtl/lsu_align.sv
// Combinational byte-lane steering for stores and extraction/extension for loads.
// The store side also flags misaligned or illegal accesses.
module lsu_align
    import rv32_mem_pkg::*;
(
    input  logic [2:0]  st_size,
    input  logic [1:0]  st_off,
    input  logic        st_we,
    input  logic [31:0] st_data,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        fault,
    input  logic [2:0]  ld_size,
    input  logic [1:0]  ld_off,
    input  logic [31:0] rdata,
    output logic [31:0] ld_data
);

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;

    always_comb begin
        be    = 4'b0000;
        wdata = st_data;
        fault = 1'b0;
        case (st_size)
            LS_B, LS_BU: begin
                be    = 4'b0001 << st_off;
                wdata = {4{st_data[7:0]}};
            end
            LS_H, LS_HU: begin
                be    = st_off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{st_data[15:0]}};
                fault = st_off[0];
            end
            LS_W: begin
                be    = 4'b1111;
                fault = |st_off;
            end
            default: fault = 1'b1;
        endcase
        // Unsigned variants only exist for loads.
        if (st_we && st_size[2])
            fault = 1'b1;
    end

    always_comb begin
        ld_byte = rdata[{ld_off, 3'b000} +: 8];
        ld_half = ld_off[1] ? rdata[31:16] : rdata[15:0];
        case (ld_size)
            LS_B:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            LS_BU:   ld_data = {24'h000000, ld_byte};
            LS_H:    ld_data = {{16{ld_half[15]}}, ld_half};
            LS_HU:   ld_data = {16'h0000, ld_half};
            default: ld_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: IDLE/BUSY/DONE req/ack FSM with timeout,
// capture registers for the bus access and registered result pulses.
module mem_stage_lsu
    import rv32_mem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid_in,
    input  logic        mem_request_write_in,
    input  logic [2:0]  mem_size_in,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_ack,
    input  logic [31:0] dmem_rdata,
    output logic        stall_out,
    output logic [31:0] load_data_out,
    output logic        load_valid_out,
    output logic        misaligned_out,
    output logic        bus_error_out
);

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

    lsu_state_t  state;
    logic [15:0] cnt;
    logic [2:0]  size_q;
    logic [1:0]  off_q;
    logic [3:0]  be_c;
    logic [31:0] wdata_c;
    logic [31:0] ld_ext;
    logic        fault_c;

    lsu_align u_align (
        .st_size (mem_size_in),
        .st_off  (addr_in[1:0]),
        .st_we   (mem_request_write_in),
        .st_data (wdata_in),
        .be      (be_c),
        .wdata   (wdata_c),
        .fault   (fault_c),
        .ld_size (size_q),
        .ld_off  (off_q),
        .rdata   (dmem_rdata),
        .ld_data (ld_ext)
    );

    assign dmem_req  = (state == BUSY);
    // Gated by reset so the pipeline is released as soon as reset asserts.
    assign stall_out = rst && (((state == IDLE) && mem_valid_in) || (state == BUSY));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= IDLE;
            cnt            <= '0;
            size_q         <= '0;
            off_q          <= '0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_be        <= '0;
            dmem_wdata     <= '0;
            load_data_out  <= '0;
            load_valid_out <= 1'b0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
        end else begin
            load_valid_out <= 1'b0;
            misaligned_out <= 1'b0;
            bus_error_out  <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_valid_in) begin
                        if (fault_c) begin
                            misaligned_out <= 1'b1;
                            state          <= DONE;
                        end else begin
                            dmem_we    <= mem_request_write_in;
                            dmem_addr  <= {addr_in[31:2], 2'b00};
                            dmem_be    <= be_c;
                            dmem_wdata <= wdata_c;
                            size_q     <= mem_size_in;
                            off_q      <= addr_in[1:0];
                            cnt        <= '0;
                            state      <= BUSY;
                        end
                    end
                end
                BUSY: begin
                    // An ack in the final allowed cycle still completes normally.
                    if (dmem_ack) begin
                        if (!dmem_we) begin
                            load_data_out  <= ld_ext;
                            load_valid_out <= 1'b1;
                        end
                        state <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        load_data_out <= '0;
                        bus_error_out <= 1'b1;
                        state         <= DONE;
                    end else begin
                        cnt <= cnt + 16'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Self-checking bench for mem_stage_lsu: directed scenarios plus randomized
// accesses checked against an arithmetic reference model.
module tb_mem_stage_lsu;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        mem_valid_in = 1'b0;
    logic        mem_request_write_in = 1'b0;
    logic [2:0]  mem_size_in = '0;
    logic [31:0] addr_in = '0;
    logic [31:0] wdata_in = '0;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        dmem_ack = 1'b0;
    logic [31:0] dmem_rdata = '0;
    logic        stall_out;
    logic [31:0] load_data_out;
    logic        load_valid_out;
    logic        misaligned_out;
    logic        bus_error_out;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_stage_lsu #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst(rst),
        .mem_valid_in(mem_valid_in), .mem_request_write_in(mem_request_write_in),
        .mem_size_in(mem_size_in), .addr_in(addr_in), .wdata_in(wdata_in),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_out(stall_out), .load_data_out(load_data_out),
        .load_valid_out(load_valid_out), .misaligned_out(misaligned_out),
        .bus_error_out(bus_error_out)
    );

    // Observations of the last access
    int          o_done;
    int          o_stall;
    bit          o_req;
    bit          o_stable;
    bit          o_we;
    logic [2:0]  o_kind;
    logic [31:0] o_addr, o_wdata, o_ld;
    logic [3:0]  o_be;

    // ---------------- reference model ----------------
    function automatic bit m_bad(input bit we, input logic [2:0] sz, input logic [31:0] a);
        bit illegal, mis;
        illegal = (sz == 3) || (sz == 6) || (sz == 7) || (we && sz[2]);
        mis     = (sz[1:0] == 2'd1 && a[0]) || (sz == 3'd2 && a[1:0] != 2'd0);
        return illegal || mis;
    endfunction

    function automatic int m_bytes(input logic [2:0] sz);
        return (sz[1:0] == 2'd0) ? 1 : (sz[1:0] == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic [3:0] m_be(input logic [2:0] sz, input logic [31:0] a);
        int nb = m_bytes(sz);
        int v  = ((1 << nb) - 1) << (a % 4);
        return v[3:0];
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] sz, input logic [31:0] d);
        int nb = m_bytes(sz);
        if (nb == 1) return (d % 256) * 32'h01010101;
        if (nb == 2) return (d % 65536) * 32'h00010001;
        return d;
    endfunction

    function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [31:0] a,
                                           input logic [31:0] rd);
        int nb = m_bytes(sz);
        logic [31:0] v, mask;
        if (nb == 4) return rd;
        v    = rd >> (8 * (a % 4));
        mask = (32'd1 << (8 * nb)) - 32'd1;
        v    = v & mask;
        if (!sz[2] && v >= (mask + 32'd1) / 2) v = v | ~mask;
        return v;
    endfunction

    // ---------------- stimulus helpers ----------------
    // Holds the request on the inputs (as a stalled EX/MEM would) until the
    // first cycle after acceptance with stall low, i.e. the DONE cycle.
    task automatic access(input bit we, input logic [2:0] sz, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] rd, input int waits,
                          input bit b2b, input bit late_ack);
        mem_valid_in = 1'b1; mem_request_write_in = we; mem_size_in = sz;
        addr_in = a; wdata_in = wd; dmem_rdata = rd; dmem_ack = 1'b0;
        if (b2b) @(negedge clk);
        o_done = -1; o_stall = 0; o_req = 0; o_stable = 1; o_kind = '0;
        o_addr = '0; o_wdata = '0; o_be = '0; o_we = 0; o_ld = '0;
        for (int c = 0; c <= TO + 6; c++) begin
            if (c > 0) begin
                @(negedge clk);
                dmem_ack = (waits >= 0) && (c == waits + 1);
            end
            #1;
            if (dmem_req) begin
                if (!o_req) begin
                    o_addr = dmem_addr; o_be = dmem_be; o_wdata = dmem_wdata; o_we = dmem_we;
                end else if ({o_addr, o_be, o_wdata, o_we} !== {dmem_addr, dmem_be, dmem_wdata, dmem_we})
                    o_stable = 0;
                o_req = 1;
            end
            if (c > 0 && !stall_out) begin
                o_done = c;
                o_kind = {load_valid_out, misaligned_out, bus_error_out};
                o_ld   = load_data_out;
                dmem_ack = late_ack;
                break;
            end
            if (stall_out) o_stall++;
        end
    endtask

    task automatic go_idle();
        mem_valid_in = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b0; mem_valid_in = 1'b1; dmem_ack = 1'b1;
        #3;
        n_tests++;
        if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, stall_out, load_data_out,
             load_valid_out, misaligned_out, bus_error_out} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: req=%b stall=%b addr=%h be=%b ld=%h",
                     dmem_req, stall_out, dmem_addr, dmem_be, load_data_out);
        end
        @(negedge clk);
        rst = 1'b1; mem_valid_in = 1'b0; dmem_ack = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_store_sw();
        access(1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h0, 0, 0, 0);
        go_idle();
        n_tests++;
        if ({o_addr, o_be, o_wdata, o_we} !== {32'h100, 4'b1111, 32'hDEADBEEF, 1'b1}) begin
            n_fail++;
            $display("FAIL sw_bus: addr=%h be=%b wdata=%h we=%b", o_addr, o_be, o_wdata, o_we);
        end
        n_tests++;
        if (o_stall !== 2 || o_done !== 2 || o_kind !== 3'b000) begin
            n_fail++;
            $display("FAIL sw_timing: stall=%0d done=%0d kind=%b want 2/2/000", o_stall, o_done, o_kind);
        end
    endtask

    task automatic test_store_sb();
        access(1, 3'b000, 32'h203, 32'h000000A5, 32'h0, 1, 0, 0);
        go_idle();
        n_tests++;
        if ({o_addr, o_be, o_wdata, o_stable} !== {32'h200, 4'b1000, 32'hA5A5A5A5, 1'b1}) begin
            n_fail++;
            $display("FAIL sb_bus: addr=%h be=%b wdata=%h stable=%b", o_addr, o_be, o_wdata, o_stable);
        end
    endtask

    task automatic test_load_ext();
        access(0, 3'b000, 32'h302, 32'h0, 32'h0080FF00, 3, 0, 0);
        go_idle();
        n_tests++;
        if (o_ld !== 32'hFFFFFF80 || o_kind !== 3'b100 || o_done !== 5) begin
            n_fail++;
            $display("FAIL lb_wait3: ld=%h kind=%b done=%0d want FFFFFF80/100/5", o_ld, o_kind, o_done);
        end
        access(0, 3'b100, 32'h302, 32'h0, 32'h0080FF00, 0, 0, 0);
        go_idle();
        n_tests++;
        if (o_ld !== 32'h00000080 || o_kind !== 3'b100) begin
            n_fail++;
            $display("FAIL lbu: ld=%h kind=%b want 00000080/100", o_ld, o_kind);
        end
    endtask

    task automatic test_misaligned();
        access(0, 3'b001, 32'h401, 32'h0, 32'h0, 0, 0, 0);
        go_idle();
        n_tests++;
        if (o_kind !== 3'b010 || o_req !== 1'b0 || o_stall !== 1 || o_done !== 1) begin
            n_fail++;
            $display("FAIL lh_misaligned: kind=%b req=%b stall=%0d done=%0d", o_kind, o_req, o_stall, o_done);
        end
    endtask

    task automatic test_timeout();
        bit bad_late = 0;
        access(0, 3'b010, 32'h500, 32'h0, 32'h12345678, -1, 0, 1);
        go_idle();
        n_tests++;
        if (o_kind !== 3'b001 || o_ld !== 32'h0 || o_done !== TO + 1 || o_stall !== TO + 1) begin
            n_fail++;
            $display("FAIL timeout: kind=%b ld=%h done=%0d stall=%0d want 001/0/%0d", o_kind, o_ld,
                     o_done, o_stall, TO + 1);
        end
        for (int i = 0; i < 3; i++) begin
            #1;
            if (dmem_req || load_valid_out || stall_out) bad_late = 1;
            @(negedge clk);
        end
        dmem_ack = 1'b0;
        n_tests++;
        if (bad_late) begin
            n_fail++;
            $display("FAIL late_ack: activity seen after timeout, got 1 want 0");
        end
    endtask

    task automatic test_back_to_back();
        access(0, 3'b101, 32'h602, 32'h0, 32'hBEEF1234, 0, 0, 0);
        access(1, 3'b001, 32'h702, 32'h0000C3D2, 32'h0, 0, 1, 0);
        go_idle();
        n_tests++;
        if ({o_addr, o_be, o_wdata} !== {32'h700, 4'b1100, 32'hC3D2C3D2} || o_done !== 2 || o_stall !== 2) begin
            n_fail++;
            $display("FAIL b2b: addr=%h be=%b wdata=%h done=%0d stall=%0d", o_addr, o_be, o_wdata,
                     o_done, o_stall);
        end
    endtask

    task automatic test_reset_busy();
        mem_valid_in = 1'b1; mem_request_write_in = 1'b0; mem_size_in = 3'b010;
        addr_in = 32'h800; dmem_ack = 1'b0;
        @(negedge clk); #1;
        n_tests++;
        if (dmem_req !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_before_reset: req=%b want 1", dmem_req);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (dmem_req !== 1'b0 || stall_out !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b stall=%b want 0/0", dmem_req, stall_out);
        end
        @(negedge clk);
        rst = 1'b1; mem_valid_in = 1'b0;
        @(negedge clk);
        access(1, 3'b010, 32'h900, 32'h01020304, 32'h0, 1, 0, 0);
        go_idle();
        n_tests++;
        if ({o_addr, o_be, o_wdata} !== {32'h900, 4'b1111, 32'h01020304} || o_done !== 3) begin
            n_fail++;
            $display("FAIL after_reset: addr=%h be=%b wdata=%h done=%0d", o_addr, o_be, o_wdata, o_done);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            bit          we    = 1'($urandom_range(0, 1));
            logic [2:0]  sz    = 3'($urandom_range(0, 7));
            logic [31:0] a     = $urandom;
            logic [31:0] wd    = $urandom;
            logic [31:0] rd    = $urandom;
            int          waits = $urandom_range(0, TO - 1);
            bit          bad   = m_bad(we, sz, a);
            int          edone = bad ? 1 : waits + 2;
            logic [2:0]  ekind = bad ? 3'b010 : (we ? 3'b000 : 3'b100);
            access(we, sz, a, wd, rd, waits, 0, 0);
            go_idle();
            n_tests++;
            if (o_kind !== ekind || o_done !== edone || o_stall !== edone || o_req !== !bad) begin
                n_fail++;
                $display("FAIL rnd%0d_flow: kind=%b/%b done=%0d/%0d stall=%0d req=%b", i, o_kind, ekind,
                         o_done, edone, o_stall, o_req);
            end
            if (!bad) begin
                n_tests++;
                if ({o_addr, o_we, o_stable} !== {a & 32'hFFFFFFFC, we, 1'b1}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_addr: addr=%h we=%b stable=%b want %h/%b/1", i, o_addr, o_we,
                             o_stable, a & 32'hFFFFFFFC, we);
                end
                n_tests++;
                if (we && {o_be, o_wdata} !== {m_be(sz, a), m_wdata(sz, wd)}) begin
                    n_fail++;
                    $display("FAIL rnd%0d_store: be=%b wdata=%h want %b/%h", i, o_be, o_wdata,
                             m_be(sz, a), m_wdata(sz, wd));
                end else if (!we && o_ld !== m_load(sz, a, rd)) begin
                    n_fail++;
                    $display("FAIL rnd%0d_load: ld=%h want %h", i, o_ld, m_load(sz, a, rd));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_store_sw();
        test_store_sb();
        test_load_ext();
        test_misaligned();
        test_timeout();
        test_back_to_back();
        test_reset_busy();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
